// File: rtl/pdivider.sv
// Iterative restoring integer divider, BITS_PER_CYCLE quotient bits per clock.
// Handles signed/unsigned operands, divide-by-zero and signed MIN/-1 overflow.
module pdivider #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             write_a,
  input  logic             start,
  input  logic             signed_ope,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              ready_q, ready_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH:0]    part_q, part_d;
  logic [WIDTH-1:0]  dsr_q, dsr_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              dbzp_q, dbzp_d;

  logic [WIDTH-1:0]  opa;
  logic              is_zero, is_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] vs;
    vs = v;
    return (sgn && vs < 0) ? WIDTH'(-vs) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // One iteration: BITS_PER_CYCLE chained restoring steps; returns {partial, quotient}.
  function automatic logic [2*WIDTH:0] div_steps(input logic [WIDTH:0] r,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   rr;
    logic [WIDTH-1:0] qq;
    rr = r;
    qq = q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rr = {rr[WIDTH-1:0], qq[WIDTH-1]};
      qq = {qq[WIDTH-2:0], 1'b0};
      if (rr >= {1'b0, d}) begin
        rr    = rr - {1'b0, d};
        qq[0] = 1'b1;
      end
    end
    return {rr, qq};
  endfunction

  // A write on the start edge is bypassed straight into the operation.
  assign opa     = write_a ? a : dvd_q;
  assign is_zero = (b == '0);
  assign is_ovf  = signed_ope && (opa == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = write_a ? a : dvd_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ready_d     = 1'b0;
    dbz_d       = dbz_q;
    work_d      = work_q;
    part_d      = part_q;
    dsr_d       = dsr_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    dbzp_d      = dbzp_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dsr_d  = mag(b, signed_ope);
          cnt_d  = CW'(N);
          negq_d = 1'b0;
          negr_d = 1'b0;
          dbzp_d = 1'b0;
          if (is_zero) begin
            // Forced results are staged so FIX can treat them like a finished division.
            work_d  = '1;
            part_d  = {1'b0, opa};
            dbzp_d  = 1'b1;
            state_d = FIX;
          end else if (is_ovf) begin
            work_d  = opa;
            part_d  = '0;
            state_d = FIX;
          end else begin
            work_d  = mag(opa, signed_ope);
            part_d  = '0;
            negq_d  = signed_ope && (opa[WIDTH-1] ^ b[WIDTH-1]);
            negr_d  = signed_ope && opa[WIDTH-1];
            state_d = CALC;
          end
        end
      end
      CALC: begin
        {part_d, work_d} = div_steps(part_q, work_q, dsr_q);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        quotient_d  = cond_neg(work_q, negq_q);
        remainder_d = cond_neg(part_q[WIDTH-1:0], negr_q);
        dbz_d       = dbzp_q;
        ready_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      ready_d     = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
      dbz_q       <= dbz_d;
    end
  end

  // Working datapath is fully reloaded at every start, so it needs no reset.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    part_q <= part_d;
    dsr_q  <= dsr_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
    dbzp_q <= dbzp_d;
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign ready       = ready_q;
  assign busy        = (state_q != IDLE);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_pdivider.sv
// Bench for pdivider: a 1-bit/cycle and a 4-bit/cycle instance checked against
// a plain-arithmetic reference model with directed and random operations.
module tb_pdivider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, write_a, start1, start4, signed_ope;
  logic [31:0] a, b;
  logic [31:0] q1, r1, q4, r4;
  logic        rdy1, bsy1, dz1, rdy4, bsy4, dz4;

  int total = 0;
  int bad   = 0;

  logic [31:0] areg;
  logic [31:0] lq[2];
  logic [31:0] lr[2];
  logic        ldz[2];

  localparam logic [31:0] MIN = 32'h8000_0000;

  pdivider #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .write_a(write_a), .start(start1),
    .signed_ope(signed_ope), .a(a), .b(b), .quotient(q1), .remainder(r1),
    .ready(rdy1), .busy(bsy1), .div_by_zero(dz1));

  pdivider #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .write_a(write_a), .start(start4),
    .signed_ope(signed_ope), .a(a), .b(b), .quotient(q4), .remainder(r4),
    .ready(rdy4), .busy(bsy4), .div_by_zero(dz4));

  function automatic logic [64:0] model(input logic [31:0] x, input logic [31:0] y, input logic sg);
    logic [31:0] q, r;
    logic        z;
    int          sx, sy;
    z = 1'b0;
    if (y == 0) begin
      q = '1; r = x; z = 1'b1;
    end else if (sg && x == MIN && y == 32'hFFFF_FFFF) begin
      q = MIN; r = 0;
    end else if (sg) begin
      sx = x; sy = y;
      q = sx / sy; r = sx % sy;
    end else begin
      q = x / y; r = x % y;
    end
    return {z, q, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: write then start; 1: start only; 2: write+start same edge; 3: start, write 50 mid-op
  task automatic do_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                       input logic sg, input int mode, input string tag);
    logic [64:0] e;
    logic [31:0] used;
    int lat, exp_lat;
    bit got;
    @(negedge clk);
    if (mode == 0) begin
      write_a = 1'b1; a = av; areg = av;
      @(negedge clk);
      write_a = 1'b0;
    end
    if (mode == 2) begin
      write_a = 1'b1; a = av; areg = av;
    end
    used = areg;
    b = bv; signed_ope = sg;
    if (sel == 1) start4 = 1'b1; else start1 = 1'b1;
    e = model(used, bv, sg);
    exp_lat = (bv == 0 || (sg && used == MIN && bv == 32'hFFFF_FFFF)) ? 1 : ((sel == 1) ? 9 : 33);
    @(posedge clk); #1;
    write_a = 1'b0; start1 = 1'b0; start4 = 1'b0;
    chk({tag, ".busy_start"}, (sel == 1) ? bsy4 : bsy1, 1);
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      if (mode == 3 && lat == 4) begin write_a = 1'b1; a = 32'd50; areg = 32'd50; end
      else write_a = 1'b0;
      @(posedge clk); #1;
      lat++;
      if ((sel == 1) ? rdy4 : rdy1) got = 1;
      else chk({tag, ".busy_run"}, (sel == 1) ? bsy4 : bsy1, 1);
    end
    write_a = 1'b0;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".quotient"}, (sel == 1) ? q4 : q1, e[63:32]);
    chk({tag, ".remainder"}, (sel == 1) ? r4 : r1, e[31:0]);
    chk({tag, ".dbz"}, (sel == 1) ? dz4 : dz1, e[64]);
    chk({tag, ".busy_done"}, (sel == 1) ? bsy4 : bsy1, 0);
    lq[sel] = e[63:32]; lr[sel] = e[31:0]; ldz[sel] = e[64];
    @(posedge clk); #1;
    chk({tag, ".ready_pulse"}, (sel == 1) ? rdy4 : rdy1, 0);
  endtask

  initial begin
    logic [64:0] e;
    logic [31:0] av, bv;
    logic        sg;
    int          cyc, last, pulses;

    rst = 1'b0; flush = 1'b0; write_a = 1'b0; start1 = 1'b0; start4 = 1'b0;
    signed_ope = 1'b0; a = '0; b = '0; areg = '0;
    #1;
    chk("rst.q", q1, 0);
    chk("rst.r", r1, 0);
    chk("rst.ready", rdy1, 0);
    chk("rst.busy", bsy1, 0);
    chk("rst.dbz", dz4, 0);
    @(negedge clk); rst = 1'b1;

    do_op(0, 32'd17, 32'd3, 1'b1, 0, "s17_3");
    chk("tp.q5", q1, 32'd5);
    chk("tp.r2", r1, 32'd2);
    do_op(0, -32'sd17, 32'd3, 1'b1, 0, "sm17_3");
    chk("tp.qm5", q1, 32'hFFFF_FFFB);
    chk("tp.rm2", r1, 32'hFFFF_FFFE);
    do_op(0, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, "u_max_2");
    chk("tp.q7f", q1, 32'h7FFF_FFFF);
    do_op(0, 32'd17, 32'd0, 1'b1, 0, "div0");
    chk("tp.div0_r", r1, 32'd17);
    do_op(0, MIN, 32'hFFFF_FFFF, 1'b1, 0, "ovf");
    chk("tp.ovf_q", q1, MIN);
    do_op(0, 32'd200, 32'd9, 1'b0, 0, "pre_flush");

    // flush at edge 10 of a 100/7 division
    @(negedge clk); write_a = 1'b1; a = 32'd100; areg = 32'd100;
    @(negedge clk); write_a = 1'b0; b = 32'd7; signed_ope = 1'b0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      chk("flush.no_ready_pre", rdy1, 0);
    end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush.busy", bsy1, 0);
    chk("flush.ready", rdy1, 0);
    chk("flush.q_hold", q1, lq[0]);
    chk("flush.r_hold", r1, lr[0]);
    chk("flush.dbz_hold", dz1, ldz[0]);
    repeat (3) begin
      @(posedge clk); #1;
      chk("flush.no_ready_post", rdy1, 0);
    end
    do_op(0, 32'd0, 32'd7, 1'b0, 3, "restart");
    chk("tp.q14", q1, 32'd14);
    chk("tp.r2b", r1, 32'd2);
    do_op(0, 32'd0, 32'd7, 1'b0, 1, "after_midwrite");

    do_op(1, 32'd91, 32'd10, 1'b0, 2, "bypass");
    do_op(1, 32'd17, 32'd0, 1'b0, 0, "div0_b4");
    do_op(1, MIN, 32'hFFFF_FFFF, 1'b1, 0, "ovf_b4");
    do_op(1, MIN, 32'd1, 1'b1, 0, "min_1");

    for (int i = 0; i < 24; i++) begin
      av = $urandom; bv = $urandom; sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: bv = 32'd1;
        1: av = 32'd0;
        2: bv = $urandom_range(1, 15);
        3: begin av = $urandom_range(0, 100); bv = 32'h1000_0000 | $urandom; end
        4: bv = -($urandom_range(1, 9));
        default: ;
      endcase
      do_op(1, av, bv, sg, 0, $sformatf("rnd%0d", i));
    end

    // start held high: results every N+2 cycles
    @(negedge clk); write_a = 1'b1; a = -32'sd1000; areg = -32'sd1000;
    @(negedge clk); write_a = 1'b0; b = 32'd7; signed_ope = 1'b1; start4 = 1'b1;
    e = model(areg, 32'd7, 1'b1);
    cyc = 0; last = 0; pulses = 0;
    while (pulses < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy4) begin
        if (pulses == 0) chk("held.first", cyc, 10);
        else chk("held.period", cyc - last, 10);
        chk("held.q", q4, e[63:32]);
        chk("held.r", r4, e[31:0]);
        last = cyc;
        pulses++;
        if (pulses == 3) start4 = 1'b0;
      end
    end
    chk("held.pulses", pulses, 3);
    @(posedge clk); #1;
    chk("held.idle", bsy4, 0);

    // asynchronous reset in the middle of CALC
    @(negedge clk); write_a = 1'b1; a = 32'd1000; areg = 32'd1000;
    @(negedge clk); write_a = 1'b0; b = 32'd3; signed_ope = 1'b0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst = 1'b0; areg = '0;
    #1;
    chk("mrst.q", q1, 0);
    chk("mrst.r", r1, 0);
    chk("mrst.ready", rdy1, 0);
    chk("mrst.busy", bsy1, 0);
    chk("mrst.dbz", dz1, 0);
    chk("mrst.q4", q4, 0);
    @(negedge clk); rst = 1'b1;
    do_op(0, 32'd0, 32'd0, 1'b0, 1, "post_rst_dvd");
    do_op(0, 32'd1000, 32'd3, 1'b0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
